fetch_unit: RTL and testbench

- Instruction fetch stage directly upstream of InstructionMem.
- Holds the program counter and drives the byte read address into InstructionMem.
- Captures the returned word into a 2-entry fetch buffer and presents it to decode over a valid/ready handshake.
- Handles control-flow redirects from execute and halts on a misaligned redirect target.

---
 rtl/fetch_unit_if.sv | 52 +++++
 rtl/fetch_unit.sv | 162 ++++++++++++++++
 tb/tb_fetch_unit.sv | 359 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fetch_unit_if.sv
// ---------------------------------------------------------------------------
// fetch_unit_if
//
// Bundles every bus signal of the instruction fetch stage:
//   - instruction memory read port:  imem_addr (byte address), imem_rdata
//   - redirect from execute:         redirect_valid, redirect_pc
//   - decode handshake:              out_valid, out_ready, out_instr, out_pc
//   - status:                        fault
//
// Modports:
//   master - the fetch unit itself (drives imem_addr, out_*, fault)
//   slave  - the surrounding environment (memory, execute, decode)
// ---------------------------------------------------------------------------
interface fetch_unit_if #(
    parameter int Depth     = 128,
    parameter int Width     = 32,
    parameter int AddrWidth = $clog2(Depth) + 2
);
    logic [AddrWidth-1:0] imem_addr;
    logic [Width-1:0]     imem_rdata;
    logic                 redirect_valid;
    logic [AddrWidth-1:0] redirect_pc;
    logic                 out_valid;
    logic                 out_ready;
    logic [Width-1:0]     out_instr;
    logic [AddrWidth-1:0] out_pc;
    logic                 fault;

    modport master (
        output imem_addr,
        input  imem_rdata,
        input  redirect_valid,
        input  redirect_pc,
        output out_valid,
        input  out_ready,
        output out_instr,
        output out_pc,
        output fault
    );

    modport slave (
        input  imem_addr,
        output imem_rdata,
        output redirect_valid,
        output redirect_pc,
        input  out_valid,
        output out_ready,
        input  out_instr,
        input  out_pc,
        input  fault
    );
endinterface

// File: rtl/fetch_unit.sv
// ---------------------------------------------------------------------------
// fetch_unit
//
// Instruction fetch stage sitting directly in front of InstructionMem. Holds
// the program counter, reads one word per cycle combinationally from the
// memory, stores it with its byte address in a 2-entry FIFO and hands the
// head to decode over a valid/ready handshake. Execute can redirect the PC;
// a misaligned redirect target halts the stage until reset.
//
// Ports:
//   clk           rising-edge clock
//   reset         synchronous, active-low reset
//   bus           fetch_unit_if.master:
//                   imem_addr      byte address to memory (equals PC)
//                   imem_rdata     word read from memory, same cycle
//                   redirect_valid one-cycle redirect request
//                   redirect_pc    redirect byte-address target
//                   out_valid      FIFO head valid
//                   out_ready      decode accepts the head
//                   out_instr      head instruction word
//                   out_pc         head byte address
//                   fault          sticky misaligned-redirect flag
//   perf_fetched  (FETCH_PERF_EN only) saturating count of pushes
//   perf_stall    (FETCH_PERF_EN only) saturating count of full-buffer stalls
//
// Optional feature macro: FETCH_PERF_EN
// ---------------------------------------------------------------------------
module fetch_unit #(
    parameter int Depth     = 128,
    parameter int Width     = 32,
    parameter int ResetPC   = 0,
    parameter int AddrWidth = $clog2(Depth) + 2
) (
    input  logic          clk,
    input  logic          reset,
    fetch_unit_if.master  bus
`ifdef FETCH_PERF_EN
    ,
    output logic [31:0]   perf_fetched,
    output logic [31:0]   perf_stall
`endif
);

    typedef enum logic {
        FETCH,
        HALT
    } state_t;

    localparam logic [AddrWidth-1:0] ResetAddr = AddrWidth'(ResetPC);
    // Address of the last word; the PC wraps to zero after it.
    localparam logic [AddrWidth-1:0] LastAddr  = AddrWidth'(4 * (Depth - 1));

    state_t               state;
    logic [AddrWidth-1:0] pc;
    logic [1:0]           count;
    logic [Width-1:0]     instr_q [2];
    logic [AddrWidth-1:0] pc_q    [2];
    logic                 fault_q;

    logic                 redirect;
    logic                 misaligned;
    logic                 pop;
    logic                 push;
    logic [AddrWidth-1:0] pc_next_seq;

    // Entry 0 is always the head, so the outputs are straight register reads.
    assign bus.imem_addr = pc;
    assign bus.out_valid = (count != 2'd0);
    assign bus.out_instr = instr_q[0];
    assign bus.out_pc    = pc_q[0];
    assign bus.fault     = fault_q;

    // A redirect wins over everything: it suppresses both the pop (the head
    // is squashed, not handed to decode) and the push. In HALT redirects are
    // ignored, and count is zero so no pop or push can happen either.
    always_comb begin
        redirect    = (state == FETCH) && bus.redirect_valid;
        misaligned  = (bus.redirect_pc[1:0] != 2'b00);
        pop         = bus.out_valid && bus.out_ready && !redirect;
        push        = (state == FETCH) && !redirect && ((count != 2'd2) || pop);
        pc_next_seq = (pc == LastAddr) ? '0 : pc + AddrWidth'(4);
    end

    // PC, state, fault and the FIFO. On a simultaneous push and pop the new
    // word lands behind whatever survives the pop, keeping the count stable.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state      <= FETCH;
            pc         <= ResetAddr;
            count      <= 2'd0;
            fault_q    <= 1'b0;
            instr_q[0] <= '0;
            instr_q[1] <= '0;
            pc_q[0]    <= '0;
            pc_q[1]    <= '0;
        end else if (redirect) begin
            count <= 2'd0;
            pc    <= {bus.redirect_pc[AddrWidth-1:2], 2'b00};
            if (misaligned) begin
                fault_q <= 1'b1;
                state   <= HALT;
            end
        end else begin
            if (push) begin
                pc <= pc_next_seq;
            end
            case ({push, pop})
                2'b10: begin
                    if (count == 2'd0) begin
                        instr_q[0] <= bus.imem_rdata;
                        pc_q[0]    <= pc;
                    end else begin
                        instr_q[1] <= bus.imem_rdata;
                        pc_q[1]    <= pc;
                    end
                    count <= count + 2'd1;
                end
                2'b01: begin
                    instr_q[0] <= instr_q[1];
                    pc_q[0]    <= pc_q[1];
                    count      <= count - 2'd1;
                end
                2'b11: begin
                    if (count == 2'd1) begin
                        instr_q[0] <= bus.imem_rdata;
                        pc_q[0]    <= pc;
                    end else begin
                        instr_q[0] <= instr_q[1];
                        pc_q[0]    <= pc_q[1];
                        instr_q[1] <= bus.imem_rdata;
                        pc_q[1]    <= pc;
                    end
                end
                default: begin
                end
            endcase
        end
    end

`ifdef FETCH_PERF_EN
    logic stall_cycle;

    // A stall is a FETCH cycle with a full buffer that decode does not drain.
    assign stall_cycle = (state == FETCH) && (count == 2'd2) && !bus.out_ready;

    // Saturating performance counters.
    always_ff @(posedge clk) begin
        if (!reset) begin
            perf_fetched <= '0;
            perf_stall   <= '0;
        end else begin
            if (push && (perf_fetched != '1)) begin
                perf_fetched <= perf_fetched + 32'd1;
            end
            if (stall_cycle && (perf_stall != '1)) begin
                perf_stall <= perf_stall + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// ---------------------------------------------------------------------------
// tb_fetch_unit
//
// Self-checking bench for fetch_unit. Directed scenarios compare against
// hand-derived constants; the random scenario compares every cycle against a
// queue-based reference model of the fetch stage. The memory model answers
// imem_addr combinationally.
// ---------------------------------------------------------------------------
module tb_fetch_unit;

    localparam int DEPTH = 128;
    localparam int WIDTH = 32;
    localparam int AW    = $clog2(DEPTH) + 2;

    typedef struct {
        logic [WIDTH-1:0] instr;
        int               pc;
    } entry_t;

    logic             clk;
    logic             reset;
    logic [WIDTH-1:0] mem [DEPTH];

    int vectors;
    int miscompares;

    // Reference model state
    entry_t m_q[$];
    int     m_pc;
    bit     m_halt;
    bit     m_fault;

    fetch_unit_if #(.Depth(DEPTH), .Width(WIDTH), .AddrWidth(AW)) bus ();

`ifdef FETCH_PERF_EN
    logic [31:0] perf_fetched;
    logic [31:0] perf_stall;
`endif

    fetch_unit #(
        .Depth(DEPTH),
        .Width(WIDTH),
        .ResetPC(0),
        .AddrWidth(AW)
    ) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus)
`ifdef FETCH_PERF_EN
        ,
        .perf_fetched(perf_fetched),
        .perf_stall(perf_stall)
`endif
    );

    assign bus.imem_rdata = mem[bus.imem_addr[AW-1:2]];

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Advances the reference model by one clock using the inputs as they
    // stand right now, then lets the DUT take the same edge.
    task automatic model_step();
        bit     pop;
        bit     do_fetch;
        entry_t e;
        if (!reset) begin
            m_q.delete();
            m_pc    = 0;
            m_halt  = 0;
            m_fault = 0;
        end else if (!m_halt) begin
            pop = (m_q.size() > 0) && bus.out_ready;
            if (bus.redirect_valid) begin
                m_q.delete();
                m_pc = int'(bus.redirect_pc) / 4 * 4;
                if (int'(bus.redirect_pc) % 4 != 0) begin
                    m_halt  = 1;
                    m_fault = 1;
                end
            end else begin
                do_fetch = (m_q.size() < 2) || pop;
                if (pop) void'(m_q.pop_front());
                if (do_fetch) begin
                    e.instr = mem[m_pc / 4];
                    e.pc    = m_pc;
                    m_q.push_back(e);
                    m_pc = (m_pc + 4) % (4 * DEPTH);
                end
            end
        end
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset              = 1'b0;
        bus.out_ready      = 1'b0;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc    = '0;
        tick();
        tick();
    endtask

    task automatic test_reset();
        $display("[TB] test_reset");
        do_reset();
        if (bus.out_valid !== 1'b0) begin
            miscompares++; $display("[TB] FAIL reset_valid: got %0b expected 0", bus.out_valid);
        end
        vectors++;
        if (bus.fault !== 1'b0) begin
            miscompares++; $display("[TB] FAIL reset_fault: got %0b expected 0", bus.fault);
        end
        vectors++;
        if (bus.imem_addr !== AW'(0)) begin
            miscompares++; $display("[TB] FAIL reset_addr: got %0h expected 0", bus.imem_addr);
        end
        vectors++;
        if (bus.out_pc !== AW'(0) || bus.out_instr !== '0) begin
            miscompares++; $display("[TB] FAIL reset_head: got pc %0h instr %0h expected 0 0", bus.out_pc, bus.out_instr);
        end
        vectors++;
    endtask

    task automatic test_stream();
        $display("[TB] test_stream");
        do_reset();
        reset         = 1'b1;
        bus.out_ready = 1'b1;
        for (int k = 0; k < 8; k++) begin
            tick();
            if (bus.out_valid !== 1'b1 || bus.out_pc !== AW'(4 * k) || bus.out_instr !== WIDTH'(k)) begin
                miscompares++;
                $display("[TB] FAIL stream_%0d: got v=%0b pc=%0h instr=%0h expected v=1 pc=%0h instr=%0h",
                         k, bus.out_valid, bus.out_pc, bus.out_instr, 4 * k, k);
            end
            vectors++;
        end
    endtask

    task automatic test_backpressure();
        $display("[TB] test_backpressure");
        do_reset();
        reset = 1'b1;
        tick();
        if (bus.out_valid !== 1'b1 || bus.imem_addr !== AW'(4)) begin
            miscompares++; $display("[TB] FAIL bp_first: got v=%0b addr=%0h expected v=1 addr=4", bus.out_valid, bus.imem_addr);
        end
        vectors++;
        for (int k = 0; k < 5; k++) begin
            tick();
            if (bus.out_valid !== 1'b1 || bus.out_pc !== AW'(0) || bus.imem_addr !== AW'(8)) begin
                miscompares++;
                $display("[TB] FAIL bp_hold_%0d: got v=%0b pc=%0h addr=%0h expected v=1 pc=0 addr=8",
                         k, bus.out_valid, bus.out_pc, bus.imem_addr);
            end
            vectors++;
        end
        bus.out_ready = 1'b1;
        for (int k = 0; k < 6; k++) begin
            if (bus.out_valid !== 1'b1 || bus.out_pc !== AW'(4 * k) || bus.out_instr !== WIDTH'(k)) begin
                miscompares++;
                $display("[TB] FAIL bp_resume_%0d: got v=%0b pc=%0h instr=%0h expected v=1 pc=%0h instr=%0h",
                         k, bus.out_valid, bus.out_pc, bus.out_instr, 4 * k, k);
            end
            vectors++;
            tick();
        end
    endtask

    task automatic test_redirect();
        $display("[TB] test_redirect");
        do_reset();
        reset = 1'b1;
        tick();
        tick();
        bus.out_ready      = 1'b1;
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = AW'(12'h040);
        tick();
        bus.redirect_valid = 1'b0;
        if (bus.out_valid !== 1'b0 || bus.imem_addr !== AW'(12'h040)) begin
            miscompares++; $display("[TB] FAIL redir_flush: got v=%0b addr=%0h expected v=0 addr=40", bus.out_valid, bus.imem_addr);
        end
        vectors++;
        tick();
        if (bus.out_valid !== 1'b1 || bus.out_pc !== AW'(12'h040) || bus.out_instr !== WIDTH'(16)) begin
            miscompares++;
            $display("[TB] FAIL redir_target: got v=%0b pc=%0h instr=%0h expected v=1 pc=40 instr=10",
                     bus.out_valid, bus.out_pc, bus.out_instr);
        end
        vectors++;
        tick();
        if (bus.out_pc !== AW'(12'h044) || bus.out_instr !== WIDTH'(17)) begin
            miscompares++; $display("[TB] FAIL redir_next: got pc=%0h instr=%0h expected pc=44 instr=11", bus.out_pc, bus.out_instr);
        end
        vectors++;
    endtask

    task automatic test_wrap();
        $display("[TB] test_wrap");
        bus.out_ready      = 1'b1;
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = AW'(12'h1FC);
        tick();
        bus.redirect_valid = 1'b0;
        tick();
        if (bus.out_valid !== 1'b1 || bus.out_pc !== AW'(12'h1FC) || bus.out_instr !== WIDTH'(127)) begin
            miscompares++;
            $display("[TB] FAIL wrap_last: got v=%0b pc=%0h instr=%0h expected v=1 pc=1fc instr=7f",
                     bus.out_valid, bus.out_pc, bus.out_instr);
        end
        vectors++;
        tick();
        if (bus.out_valid !== 1'b1 || bus.out_pc !== AW'(0) || bus.out_instr !== WIDTH'(0)) begin
            miscompares++;
            $display("[TB] FAIL wrap_zero: got v=%0b pc=%0h instr=%0h expected v=1 pc=0 instr=0",
                     bus.out_valid, bus.out_pc, bus.out_instr);
        end
        vectors++;
    endtask

    task automatic test_misaligned();
        $display("[TB] test_misaligned");
        bus.out_ready      = 1'b1;
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = AW'(12'h042);
        tick();
        bus.redirect_valid = 1'b0;
        for (int k = 0; k < 3; k++) begin
            if (bus.fault !== 1'b1 || bus.out_valid !== 1'b0 || bus.imem_addr !== AW'(12'h040)) begin
                miscompares++;
                $display("[TB] FAIL halt_%0d: got fault=%0b v=%0b addr=%0h expected fault=1 v=0 addr=40",
                         k, bus.fault, bus.out_valid, bus.imem_addr);
            end
            vectors++;
            tick();
        end
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = AW'(12'h010);
        tick();
        bus.redirect_valid = 1'b0;
        tick();
        if (bus.fault !== 1'b1 || bus.out_valid !== 1'b0 || bus.imem_addr !== AW'(12'h040)) begin
            miscompares++;
            $display("[TB] FAIL halt_ignore: got fault=%0b v=%0b addr=%0h expected fault=1 v=0 addr=40",
                     bus.fault, bus.out_valid, bus.imem_addr);
        end
        vectors++;
        reset = 1'b0;
        tick();
        if (bus.fault !== 1'b0 || bus.imem_addr !== AW'(0)) begin
            miscompares++; $display("[TB] FAIL halt_reset: got fault=%0b addr=%0h expected fault=0 addr=0", bus.fault, bus.imem_addr);
        end
        vectors++;
        reset = 1'b1;
        tick();
        if (bus.out_valid !== 1'b1 || bus.out_pc !== AW'(0)) begin
            miscompares++; $display("[TB] FAIL halt_restart: got v=%0b pc=%0h expected v=1 pc=0", bus.out_valid, bus.out_pc);
        end
        vectors++;
    endtask

    task automatic test_reset_midstream();
        $display("[TB] test_reset_midstream");
        bus.out_ready = 1'b1;
        tick();
        tick();
        tick();
        bus.out_ready = 1'b0;
        tick();
        tick();
        reset = 1'b0;
        tick();
        if (bus.out_valid !== 1'b0 || bus.out_pc !== AW'(0) || bus.out_instr !== '0) begin
            miscompares++;
            $display("[TB] FAIL mid_reset: got v=%0b pc=%0h instr=%0h expected v=0 pc=0 instr=0",
                     bus.out_valid, bus.out_pc, bus.out_instr);
        end
        vectors++;
`ifdef FETCH_PERF_EN
        if (perf_fetched !== 32'd0 || perf_stall !== 32'd0) begin
            miscompares++; $display("[TB] FAIL mid_perf: got fetched=%0d stall=%0d expected 0 0", perf_fetched, perf_stall);
        end
        vectors++;
`endif
        reset         = 1'b1;
        bus.out_ready = 1'b1;
        tick();
        if (bus.out_valid !== 1'b1 || bus.out_pc !== AW'(0)) begin
            miscompares++; $display("[TB] FAIL mid_restart: got v=%0b pc=%0h expected v=1 pc=0", bus.out_valid, bus.out_pc);
        end
        vectors++;
    endtask

    task automatic test_random();
        int r;
        $display("[TB] test_random");
        for (int i = 0; i < DEPTH; i++) mem[i] = $urandom;
        do_reset();
        for (int cyc = 0; cyc < 600; cyc++) begin
            reset              = ($urandom_range(0, 63) != 0);
            bus.out_ready      = ($urandom_range(0, 3) != 0);
            bus.redirect_valid = ($urandom_range(0, 15) == 0);
            r                  = $urandom_range(0, 3);
            bus.redirect_pc    = AW'($urandom_range(0, 4 * DEPTH - 1) & ((r == 0) ? 32'hFFFF_FFFF : 32'hFFFF_FFFC));
            tick();
            if (bus.out_valid !== (m_q.size() > 0) || bus.fault !== m_fault || bus.imem_addr !== AW'(m_pc)) begin
                miscompares++;
                $display("[TB] FAIL rand_ctrl_%0d: got v=%0b fault=%0b addr=%0h expected v=%0b fault=%0b addr=%0h",
                         cyc, bus.out_valid, bus.fault, bus.imem_addr, (m_q.size() > 0), m_fault, m_pc);
            end
            vectors++;
            if (m_q.size() > 0) begin
                if (bus.out_pc !== AW'(m_q[0].pc) || bus.out_instr !== m_q[0].instr) begin
                    miscompares++;
                    $display("[TB] FAIL rand_head_%0d: got pc=%0h instr=%0h expected pc=%0h instr=%0h",
                             cyc, bus.out_pc, bus.out_instr, m_q[0].pc, m_q[0].instr);
                end
                vectors++;
            end
        end
        bus.redirect_valid = 1'b0;
        reset              = 1'b1;
    endtask

    initial begin
        vectors            = 0;
        miscompares        = 0;
        reset              = 1'b0;
        bus.out_ready      = 1'b0;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc    = '0;
        m_pc               = 0;
        m_halt             = 0;
        m_fault            = 0;
        for (int i = 0; i < DEPTH; i++) mem[i] = WIDTH'(i);

        test_reset();
        test_stream();
        test_backpressure();
        test_redirect();
        test_wrap();
        test_misaligned();
        test_reset_midstream();
        test_random();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
